lsu: RTL and testbench

Load/store unit sitting directly downstream of the control signal generator in the NPC core. It consumes the decoded `mem_rd_en`, `mem_wr_en` and `mem_op` signals together with the ALU-computed address and the rs2 store data. It runs one memory transaction at a time over a valid/ready data bus, then returns the sign- or zero-extended load result for the `mem2reg` writeback path. It handles byte-lane alignment, write strobes and misalignment detection, and stalls the core through a request handshake.

---
 rtl/lsu_if.sv | 49 ++++
 rtl/lsu.sv | 164 ++++++++++++++++
 tb/tb_lsu.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_if
// Brief    : Bundle for the LSU. It carries the core-side request/response
//            channel and the downstream valid/ready data bus.
//            The slave modport is the LSU's view. The master modport is the
//            view of the environment that drives the core and bus inputs.
// Revision : 1.0  initial release
// ============================================================================
interface lsu_if;
    // core request / response channel
    logic        req_valid;
    logic        req_ready;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] rdata;
    // data bus channel
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_resp_valid;
    logic        bus_resp_ready;
    logic [31:0] bus_rdata;

    modport slave (
        input  req_valid, mem_rd_en, mem_wr_en, mem_op, addr, wdata,
        input  bus_req_ready, bus_resp_valid, bus_rdata,
        output req_ready, resp_valid, resp_err, rdata,
        output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_resp_ready
    );

    modport master (
        output req_valid, mem_rd_en, mem_wr_en, mem_op, addr, wdata,
        output bus_req_ready, bus_resp_valid, bus_rdata,
        input  req_ready, resp_valid, resp_err, rdata,
        input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_resp_ready
    );
endinterface
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Brief    : Load/store unit. It runs one memory transaction at a time over a
//            valid/ready bus and handles lane alignment, write strobes and
//            misalignment/illegal-op errors. Load results are sign- or
//            zero-extended.
// Revision : 1.0  initial release
// ============================================================================
module lsu (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  io
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // request fields captured on accept
    logic        r_is_load;
    logic        r_err;
    logic [2:0]  r_op;
    logic [1:0]  r_off;
    logic [31:0] r_rdata;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_wstrb;

    // request decode (from live inputs, only meaningful on accept)
    logic        w_accept;
    logic        w_any;
    logic        w_op_legal;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misalign;
    logic        w_err;
    logic        w_go_bus;
    logic        w_is_store;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;

    // load extraction
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    assign w_accept = (r_state == S_IDLE) && io.req_valid;

    // Classify the incoming request and build its lane strobes and lane data.
    always_comb begin
        w_op_legal = 1'b0;
        w_is_byte  = 1'b0;
        w_is_half  = 1'b0;
        w_is_word  = 1'b0;
        case (io.mem_op)
            3'b000, 3'b100: begin w_op_legal = 1'b1; w_is_byte = 1'b1; end
            3'b001, 3'b101: begin w_op_legal = 1'b1; w_is_half = 1'b1; end
            3'b010:         begin w_op_legal = 1'b1; w_is_word = 1'b1; end
            default:        w_op_legal = 1'b0;
        endcase

        w_any      = io.mem_rd_en | io.mem_wr_en;
        w_misalign = (w_is_half & io.addr[0]) | (w_is_word & (|io.addr[1:0]));
        // The op field only matters when an enable is set. A request with no
        // enable is a no-op and never an error.
        w_err      = (io.mem_rd_en & io.mem_wr_en)
                   | (w_any & (~w_op_legal | w_misalign));
        w_go_bus   = w_any & ~w_err;
        w_is_store = io.mem_wr_en & w_go_bus;

        w_strb  = 4'b1111;
        w_wdata = io.wdata;
        if (w_is_byte) begin
            w_strb  = 4'b0001 << io.addr[1:0];
            w_wdata = {4{io.wdata[7:0]}};
        end else if (w_is_half) begin
            w_strb  = 4'b0011 << io.addr[1:0];
            w_wdata = {2{io.wdata[15:0]}};
        end
    end

    // Align the returned word to the accessed lane, then extend it by format.
    always_comb begin
        w_shifted = io.bus_rdata >> {r_off, 3'b000};
        case (r_op)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. Errors and no-ops go straight to DONE without touching the bus.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (io.req_valid)     w_state_next = w_go_bus ? S_REQ : S_DONE;
            S_REQ:  if (io.bus_req_ready) w_state_next = S_RESP;
            S_RESP: if (io.bus_resp_valid) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Capture request fields on accept. Load data is captured when the bus response arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_load   <= 1'b0;
            r_err       <= 1'b0;
            r_op        <= 3'd0;
            r_off       <= 2'd0;
            r_rdata     <= 32'd0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_bus_wstrb <= 4'd0;
        end else if (w_accept) begin
            r_is_load   <= io.mem_rd_en & w_go_bus;
            r_err       <= w_err;
            r_op        <= io.mem_op;
            r_off       <= io.addr[1:0];
            // rdata reads as zero for stores, errors and no-ops.
            r_rdata     <= 32'd0;
            r_bus_we    <= w_is_store;
            r_bus_addr  <= {io.addr[31:2], 2'b00};
            r_bus_wdata <= w_is_store ? w_wdata : 32'd0;
            r_bus_wstrb <= w_is_store ? w_strb : 4'd0;
        end else if ((r_state == S_RESP) && io.bus_resp_valid && r_is_load) begin
            r_rdata     <= w_load_data;
        end
    end

    // Handshake outputs are decoded from state only.
    assign io.req_ready      = (r_state == S_IDLE);
    assign io.bus_req_valid  = (r_state == S_REQ);
    assign io.bus_resp_ready = (r_state == S_RESP);
    assign io.resp_valid     = (r_state == S_DONE);
    assign io.resp_err       = (r_state == S_DONE) & r_err;
    assign io.rdata          = r_rdata;
    assign io.bus_we         = r_bus_we;
    assign io.bus_addr       = r_bus_addr;
    assign io.bus_wdata      = r_bus_wdata;
    assign io.bus_wstrb      = r_bus_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Brief    : Self-checking bench for lsu. It has directed vector table,
//            randomized traffic against a reference model, and reset and
//            handshake corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if bus ();
    lsu dut (.clk(clk), .rst_n(rst_n), .io(bus));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit        err;
        bit        bus;
        bit        we;
        bit [3:0]  strb;
        bit [31:0] bwdata;
        bit [31:0] baddr;
        bit [31:0] rdata;
        int        lat;
    } exp_t;

    typedef struct {
        bit        err;
        bit        bus;
        bit        we;
        bit [3:0]  strb;
        bit [31:0] bwdata;
        bit [31:0] baddr;
        bit [31:0] rdata;
        int        lat;
        bit        stable;
        bit        pulse_ok;
        bit        held;
    } obs_t;

    typedef struct {
        bit        rd;
        bit        wr;
        bit [2:0]  op;
        bit [31:0] a;
        bit [31:0] wd;
        bit [31:0] rdw;
        int        rqw;
        int        rsw;
        bit        xerr;
        bit        xbus;
        bit [31:0] xrdata;
        bit [3:0]  xstrb;
        bit [31:0] xbw;
        int        xlat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model. It works from access size, lane offset and arithmetic sign extension.
    function automatic exp_t model(input bit rd, input bit wr, input bit [2:0] op,
                                   input bit [31:0] a, input bit [31:0] wd,
                                   input bit [31:0] rdw, input int rqw, input int rsw);
        exp_t   e;
        int     size;
        int     o;
        bit     sgn;
        bit     legal;
        longint v;
        e = '{default: 0};
        o = int'(a % 4);
        e.baddr = a - 32'(o);
        legal = 1'b1; sgn = 1'b0; size = 4;
        case (op)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: legal = 1'b0;
        endcase
        e.lat = 1;
        if (!rd && !wr) return e;
        if ((rd && wr) || !legal || (o % size != 0)) begin
            e.err = 1'b1;
            return e;
        end
        e.bus = 1'b1;
        e.we  = wr;
        e.lat = 3 + rqw + rsw;
        if (wr) begin
            e.strb = 4'(((1 << size) - 1) << o);
            for (int i = 0; i < 4; i++) e.bwdata[8*i +: 8] = 8'(wd >> (8 * (i % size)));
        end else begin
            v = longint'(rdw >> (8 * o));
            if (size < 4) begin
                v = v % (longint'(1) << (8 * size));
                if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
            end
            e.rdata = 32'(v);
        end
        return e;
    endfunction

    // Drive one request from IDLE, act as the bus with the given wait states, and observe.
    task automatic run_txn(input bit rd, input bit wr, input bit [2:0] op,
                           input bit [31:0] a, input bit [31:0] wd, input bit [31:0] rdw,
                           input int rqw, input int rsw, output obs_t o);
        int  rq_left;
        int  rs_left;
        int  k;
        bit  first;
        bit  done;
        o = '{default: 0};
        o.stable = 1'b1;
        o.lat = -1;
        check("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.mem_rd_en = rd; bus.mem_wr_en = wr;
        bus.mem_op = op; bus.addr = a; bus.wdata = wd;
        bus.bus_req_ready = 1'b0; bus.bus_resp_valid = 1'b0;
        @(posedge clk); #1;
        // Scramble the request inputs to show they were latched.
        bus.req_valid = 1'b0;
        bus.mem_rd_en = 1'($urandom); bus.mem_wr_en = 1'($urandom);
        bus.mem_op = 3'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
        rq_left = rqw; rs_left = rsw; first = 1'b1; done = 1'b0; k = 1;
        while (!done && k <= 40) begin
            if (bus.resp_valid) begin
                o.lat = k; o.err = bus.resp_err; o.rdata = bus.rdata;
                done = 1'b1;
            end else begin
                if (bus.bus_req_valid) begin
                    if (first) begin
                        o.bus = 1'b1; o.we = bus.bus_we; o.strb = bus.bus_wstrb;
                        o.bwdata = bus.bus_wdata; o.baddr = bus.bus_addr;
                        first = 1'b0;
                    end else if (o.we != bus.bus_we || o.strb != bus.bus_wstrb ||
                                 o.bwdata != bus.bus_wdata || o.baddr != bus.bus_addr) begin
                        o.stable = 1'b0;
                    end
                    bus.bus_req_ready = (rq_left == 0);
                    if (rq_left > 0) rq_left--;
                end else begin
                    bus.bus_req_ready = 1'($urandom);
                end
                if (bus.bus_resp_ready) begin
                    bus.bus_resp_valid = (rs_left == 0);
                    bus.bus_rdata = (rs_left == 0) ? rdw : $urandom;
                    if (rs_left > 0) rs_left--;
                end else begin
                    // Responses outside RESP must be ignored.
                    bus.bus_resp_valid = 1'($urandom);
                    bus.bus_rdata = $urandom;
                end
                @(posedge clk); #1;
                k++;
            end
        end
        bus.bus_req_ready = 1'b0; bus.bus_resp_valid = 1'b0;
        @(posedge clk); #1;
        o.pulse_ok = !bus.resp_valid && bus.req_ready;
        o.held = (bus.rdata == o.rdata);
    endtask

    task automatic compare(input string tag, input exp_t e, input obs_t o);
        check({tag, ".lat"}, 32'(o.lat), 32'(e.lat));
        check({tag, ".err"}, 32'(o.err), 32'(e.err));
        check({tag, ".rdata"}, o.rdata, e.rdata);
        check({tag, ".bus_seen"}, 32'(o.bus), 32'(e.bus));
        if (e.bus) begin
            check({tag, ".bus_addr"}, o.baddr, e.baddr);
            check({tag, ".bus_we"}, 32'(o.we), 32'(e.we));
            check({tag, ".bus_wstrb"}, 32'(o.strb), 32'(e.strb));
            if (e.we) check({tag, ".bus_wdata"}, o.bwdata, e.bwdata);
            check({tag, ".stable"}, 32'(o.stable), 32'd1);
        end
        check({tag, ".pulse"}, 32'(o.pulse_ok), 32'd1);
        check({tag, ".held"}, 32'(o.held), 32'd1);
    endtask

    vec_t vt[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        exp_t e;
        bit        rd, wr;
        bit [2:0]  op;
        bit [31:0] a, wd, rdw;
        int        rqw, rsw;
        int        accepts, pulses, bad_width, brv_rises, idx;
        bit        prev_rv, prev_brv;
        bit [31:0] p_rdata[2];
        bit        p_err[2];

        vt[0]  = '{1, 0, 3'b000, 32'h8000_0003, 32'h0,         32'h8012_3456, 0, 0, 0, 1, 32'hFFFF_FF80, 4'b0000, 32'h0,         3};
        vt[1]  = '{1, 0, 3'b101, 32'h0000_0002, 32'h0,         32'hBEEF_1234, 0, 0, 0, 1, 32'h0000_BEEF, 4'b0000, 32'h0,         3};
        vt[2]  = '{1, 0, 3'b001, 32'h0000_0002, 32'h0,         32'hBEEF_1234, 0, 0, 0, 1, 32'hFFFF_BEEF, 4'b0000, 32'h0,         3};
        vt[3]  = '{0, 1, 3'b001, 32'h0000_0006, 32'hAAAA_C3D4, 32'h0,         2, 0, 0, 1, 32'h0,         4'b1100, 32'hC3D4_C3D4, 5};
        vt[4]  = '{1, 0, 3'b010, 32'h0000_0001, 32'h0,         32'h0,         0, 0, 1, 0, 32'h0,         4'b0000, 32'h0,         1};
        vt[5]  = '{1, 0, 3'b001, 32'h0000_0003, 32'h0,         32'h0,         0, 0, 1, 0, 32'h0,         4'b0000, 32'h0,         1};
        vt[6]  = '{1, 0, 3'b110, 32'h0000_0000, 32'h0,         32'h0,         0, 0, 1, 0, 32'h0,         4'b0000, 32'h0,         1};
        vt[7]  = '{1, 1, 3'b010, 32'h0000_0000, 32'h0,         32'h0,         0, 0, 1, 0, 32'h0,         4'b0000, 32'h0,         1};
        vt[8]  = '{0, 0, 3'b010, 32'h0000_0040, 32'h0,         32'h0,         0, 0, 0, 0, 32'h0,         4'b0000, 32'h0,         1};
        vt[9]  = '{0, 1, 3'b000, 32'h0000_0011, 32'h1234_56A5, 32'h0,         0, 0, 0, 1, 32'h0,         4'b0010, 32'hA5A5_A5A5, 3};
        vt[10] = '{1, 0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 3, 0, 1, 32'hDEAD_BEEF, 4'b0000, 32'h0,         6};
        vt[11] = '{1, 0, 3'b100, 32'h0000_0001, 32'h0,         32'h0000_F600, 1, 1, 0, 1, 32'h0000_00F6, 4'b0000, 32'h0,         5};
        vt[12] = '{0, 1, 3'b010, 32'h0000_0020, 32'hCAFE_BABE, 32'h0,         1, 0, 0, 1, 32'h0,         4'b1111, 32'hCAFE_BABE, 4};

        bus.req_valid = 1'b0; bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0;
        bus.mem_op = 3'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
        bus.bus_req_ready = 1'b0; bus.bus_resp_valid = 1'b0; bus.bus_rdata = 32'd0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst.req_ready", 32'(bus.req_ready), 32'd1);
        check("rst.bus_req_valid", 32'(bus.bus_req_valid), 32'd0);
        check("rst.bus_we", 32'(bus.bus_we), 32'd0);
        check("rst.bus_wstrb", 32'(bus.bus_wstrb), 32'd0);
        check("rst.bus_resp_ready", 32'(bus.bus_resp_ready), 32'd0);
        check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst.resp_err", 32'(bus.resp_err), 32'd0);
        check("rst.rdata", bus.rdata, 32'd0);
        check("rst.bus_addr", bus.bus_addr, 32'd0);
        check("rst.bus_wdata", bus.bus_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            run_txn(vt[i].rd, vt[i].wr, vt[i].op, vt[i].a, vt[i].wd, vt[i].rdw,
                    vt[i].rqw, vt[i].rsw, o);
            check($sformatf("vec%0d.lat", i), 32'(o.lat), 32'(vt[i].xlat));
            check($sformatf("vec%0d.err", i), 32'(o.err), 32'(vt[i].xerr));
            check($sformatf("vec%0d.rdata", i), o.rdata, vt[i].xrdata);
            check($sformatf("vec%0d.bus_seen", i), 32'(o.bus), 32'(vt[i].xbus));
            if (vt[i].xbus) begin
                check($sformatf("vec%0d.bus_addr", i), o.baddr, {vt[i].a[31:2], 2'b00});
                check($sformatf("vec%0d.bus_wstrb", i), 32'(o.strb), 32'(vt[i].xstrb));
                check($sformatf("vec%0d.stable", i), 32'(o.stable), 32'd1);
                if (vt[i].wr) check($sformatf("vec%0d.bus_wdata", i), o.bwdata, vt[i].xbw);
            end
            check($sformatf("vec%0d.pulse", i), 32'(o.pulse_ok), 32'd1);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 80; n++) begin
            rd = 1'($urandom); wr = 1'($urandom); op = 3'($urandom);
            a = $urandom; wd = $urandom; rdw = $urandom;
            rqw = int'($urandom_range(0, 3)); rsw = int'($urandom_range(0, 3));
            if (!rd && !wr) a[1:0] = 2'b00;
            e = model(rd, wr, op, a, wd, rdw, rqw, rsw);
            run_txn(rd, wr, op, a, wd, rdw, rqw, rsw, o);
            compare($sformatf("rnd%0d", n), e, o);
        end

        // Reset while waiting in RESP
        bus.req_valid = 1'b1; bus.mem_rd_en = 1'b1; bus.mem_wr_en = 1'b0;
        bus.mem_op = 3'b010; bus.addr = 32'h0000_0200;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.bus_req_ready = 1'b0; bus.bus_resp_valid = 1'b0;
        check("midrst.in_resp", 32'(bus.bus_resp_ready), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst.req_ready", 32'(bus.req_ready), 32'd1);
        check("midrst.bus_req_valid", 32'(bus.bus_req_valid), 32'd0);
        check("midrst.bus_resp_ready", 32'(bus.bus_resp_ready), 32'd0);
        check("midrst.bus_addr", bus.bus_addr, 32'd0);
        check("midrst.bus_wstrb", 32'(bus.bus_wstrb), 32'd0);
        check("midrst.bus_we", 32'(bus.bus_we), 32'd0);
        check("midrst.resp_valid", 32'(bus.resp_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h1234_5678, 0, 0, o);
        check("midrst.reload_rdata", o.rdata, 32'h1234_5678);
        check("midrst.reload_lat", 32'(o.lat), 32'd3);

        // Handshake discipline: req_valid held while two ops are queued
        accepts = 0; pulses = 0; bad_width = 0; brv_rises = 0; idx = 0;
        prev_rv = 1'b0; prev_brv = 1'b0;
        p_rdata[0] = 32'h0; p_rdata[1] = 32'h0; p_err[0] = 1'b0; p_err[1] = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (bus.resp_valid) begin
                if (prev_rv) bad_width++;
                if (pulses < 2) begin
                    p_rdata[pulses] = bus.rdata;
                    p_err[pulses] = bus.resp_err;
                end
                pulses++;
            end
            prev_rv = bus.resp_valid;
            if (bus.bus_req_valid && !prev_brv) brv_rises++;
            prev_brv = bus.bus_req_valid;
            if (idx < 2) begin
                bus.req_valid = 1'b1; bus.mem_rd_en = 1'b1; bus.mem_wr_en = 1'b0;
                bus.mem_op = 3'b010;
                bus.addr = (idx == 0) ? 32'h0000_0040 : 32'h0000_0041;
                if (bus.req_ready) begin
                    accepts++;
                    idx++;
                end
            end else begin
                bus.req_valid = 1'b0;
            end
            bus.bus_req_ready = (cyc >= 6);
            bus.bus_resp_valid = 1'b1;
            bus.bus_rdata = 32'h0BAD_F00D;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0; bus.bus_req_ready = 1'b0; bus.bus_resp_valid = 1'b0;
        check("hs.accepts", 32'(accepts), 32'd2);
        check("hs.pulses", 32'(pulses), 32'd2);
        check("hs.pulse_width", 32'(bad_width), 32'd0);
        check("hs.bus_requests", 32'(brv_rises), 32'd1);
        check("hs.first_rdata", p_rdata[0], 32'h0BAD_F00D);
        check("hs.first_err", 32'(p_err[0]), 32'd0);
        check("hs.second_err", 32'(p_err[1]), 32'd1);
        check("hs.second_rdata", p_rdata[1], 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
